ft245_cmd_parser: RTL
=====================

FT245_CMD_PARSER -- requirements
Module: ft245_cmd_parser

Interface
REQ-001 Parameter NUM_REGS, default 32: count of valid register addresses, 0..NUM_REGS-1.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: idle cycles allowed between bytes of one frame.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_to_fpga  input  8  received byte from the FT245 FIFO interface.
REQ-006 rx_strobe  input  1  one-cycle pulse; data_to_fpga valid this cycle.
REQ-007 _read_data  output  1  low = parser requests/accepts a received byte.
REQ-008 data_to_pc  output  8  response byte to the FT245 FIFO interface.
REQ-009 _write_data  output  1  low = response byte pending on data_to_pc.
REQ-010 tx_ack  input  1  one-cycle pulse; pending response byte taken by the host link.
REQ-011 reg_addr  output  8  register-bank address.
REQ-012 reg_wdata  output  8  register-bank write data.
REQ-013 reg_we  output  1  one-cycle register write strobe.
REQ-014 reg_rdata  input  8  register-bank read data, combinational from reg_addr.
REQ-015 frame_count  output  8  count of successfully executed frames.
REQ-016 err_count  output  8  count of rejected or timed-out frames.
REQ-017 overrun  output  1  sticky flag: byte arrived while parser busy.

Function
REQ-018 A frame is exactly 3 bytes: command, address, data; 0x57 ('W') is write, 0x52 ('R') is read, and the data byte of a read is ignored.
REQ-019 The state machine has states IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
REQ-020 IDLE: on rx_strobe, latch command, go GET_ADDR; GET_ADDR: on rx_strobe, latch address, go GET_DATA; GET_DATA: on rx_strobe, latch data, go EXEC.
REQ-021 _read_data is low in IDLE, GET_ADDR, GET_DATA and high in EXEC and SEND.
REQ-022 EXEC lasts exactly one cycle, drives reg_addr with the latched address, then goes to SEND.
REQ-023 In EXEC, a write with address < NUM_REGS pulses reg_we for that cycle with reg_wdata = latched data; the response is 0xAA.
REQ-024 In EXEC, a read with address < NUM_REGS captures reg_rdata as the response; reg_we stays low.
REQ-025 In EXEC, an unknown command or address >= NUM_REGS gives response 0xEE, no reg_we, and err_count increments.
REQ-026 Valid frames increment frame_count in EXEC.
REQ-027 SEND: _write_data low and data_to_pc holds the response until tx_ack; on tx_ack go IDLE with _write_data high the next cycle.
REQ-028 Response latency: _write_data falls 2 cycles after the rx_strobe carrying the data byte.
REQ-029 Timeout: a counter clears on each rx_strobe and increments every cycle in GET_ADDR/GET_DATA.
REQ-030 On reaching TIMEOUT_CYCLES, go IDLE, discard the partial frame, increment err_count, and send no response.
REQ-031 The timeout does not apply in IDLE, EXEC or SEND; SEND waits indefinitely for tx_ack.
REQ-032 An rx_strobe in EXEC or SEND is dropped and sets overrun; only reset clears overrun.
REQ-033 A tx_ack outside SEND is ignored.
REQ-034 frame_count wraps from 255 to 0; err_count saturates at 255.
REQ-035 If timeout and rx_strobe coincide in the same cycle, rx_strobe wins: the byte is accepted and the counter clears.

Reset
REQ-036 While reset is high at a clock edge, the state machine enters IDLE and the following outputs are forced: _write_data=1, _read_data=1, data_to_pc=0x00, reg_addr=0x00, reg_wdata=0x00, reg_we=0, frame_count=0, err_count=0, overrun=0, timeout counter=0.
REQ-037 Reset mid-frame or mid-SEND discards all latched bytes and the pending response; no reg_we is issued.
REQ-038 _read_data goes low on the first clock after reset is released.

Verification
REQ-039 Write: bytes 0x57,0x05,0x3C -> reg_we one cycle with reg_addr=0x05, reg_wdata=0x3C; data_to_pc=0xAA; frame_count=1.
REQ-040 Read: reg_rdata=0x81 at address 0x02; bytes 0x52,0x02,0x00 -> data_to_pc=0x81, no reg_we; tx_ack returns to IDLE.
REQ-041 Error: bytes 0x41,0x00,0x00 -> 0xEE; bytes 0x57,0x20,0x11 (NUM_REGS=32) -> 0xEE, no reg_we; err_count=2.
REQ-042 Timeout (TIMEOUT_CYCLES=10): 0x57 then 10 idle cycles -> IDLE, err_count=1, _write_data stays high; next frame executes normally.
REQ-043 Overrun/backpressure: hold tx_ack low 100 cycles in SEND and pulse rx_strobe -> _write_data stays low, byte dropped, overrun=1.
REQ-044 Reset in GET_DATA and in SEND -> all outputs at reset values, no reg_we, subsequent frame correct.

Source files
------------

// File: rtl/ft245_cmd_parser_if.sv
// FT245 host-link and register-bank signals of the command parser; master = host/bank side, slave = parser.
interface ft245_cmd_parser_if;
    logic [7:0] data_to_fpga;
    logic       rx_strobe;
    logic       _read_data;
    logic [7:0] data_to_pc;
    logic       _write_data;
    logic       tx_ack;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic [7:0] frame_count;
    logic [7:0] err_count;
    logic       overrun;

    modport master (
        output data_to_fpga, rx_strobe, tx_ack, reg_rdata,
        input  _read_data, data_to_pc, _write_data, reg_addr, reg_wdata, reg_we,
               frame_count, err_count, overrun
    );

    modport slave (
        input  data_to_fpga, rx_strobe, tx_ack, reg_rdata,
        output _read_data, data_to_pc, _write_data, reg_addr, reg_wdata, reg_we,
               frame_count, err_count, overrun
    );
endinterface

// File: rtl/ft245_cmd_parser.sv
// 3-byte command/address/data parser driving a register bank; response pending 2 cycles after the data byte.
// Response is held in SEND until tx_ack; bytes arriving in EXEC/SEND are dropped and flag overrun.
module ft245_cmd_parser #(
    parameter int NUM_REGS       = 32,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    ft245_cmd_parser_if.slave     bus
);
    localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]     NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [7:0]     CMD_WRITE  = 8'h57;
    localparam logic [7:0]     CMD_READ   = 8'h52;
    localparam logic [7:0]     RESP_OK    = 8'hAA;
    localparam logic [7:0]     RESP_ERR   = 8'hEE;

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic [7:0]     resp_q, resp_d;
    logic [7:0]     frame_q, frame_d;
    logic [7:0]     err_q, err_d;
    logic           overrun_q, overrun_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           read_n_q, read_n_d;
    logic           write_n_q, write_n_d;
    logic           reg_we_c;
    logic           is_write, is_read, addr_ok;
    logic [7:0]     err_inc;

    assign is_write = (cmd_q == CMD_WRITE);
    assign is_read  = (cmd_q == CMD_READ);
    assign addr_ok  = ({1'b0, addr_q} < NUM_REGS_W);
    assign err_inc  = err_q + {7'd0, (err_q != 8'hFF)};

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        frame_d   = frame_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        tmo_d     = tmo_q;
        reg_we_c  = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (bus.rx_strobe) begin
                    cmd_d   = bus.data_to_fpga;
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR, GET_DATA: begin
                // A byte arriving on the timeout cycle still counts as in time.
                if (bus.rx_strobe) begin
                    tmo_d = '0;
                    if (state_q == GET_ADDR) begin
                        addr_d  = bus.data_to_fpga;
                        state_d = GET_DATA;
                    end else begin
                        data_d  = bus.data_to_fpga;
                        state_d = EXEC;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    err_d   = err_inc;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            EXEC: begin
                state_d = SEND;
                if ((is_write || is_read) && addr_ok) begin
                    frame_d  = frame_q + 8'd1;
                    reg_we_c = is_write;
                    resp_d   = is_write ? RESP_OK : bus.reg_rdata;
                end else begin
                    err_d  = err_inc;
                    resp_d = RESP_ERR;
                end
            end
            SEND: begin
                if (bus.tx_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.rx_strobe && (state_q == EXEC || state_q == SEND)) begin
            overrun_d = 1'b1;
        end

        read_n_d  = (state_d == EXEC) || (state_d == SEND);
        write_n_d = (state_d != SEND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= 8'h00;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            resp_q    <= 8'h00;
            frame_q   <= 8'h00;
            err_q     <= 8'h00;
            overrun_q <= 1'b0;
            tmo_q     <= '0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
        end
    end

    assign bus._read_data  = read_n_q;
    assign bus._write_data = write_n_q;
    assign bus.data_to_pc  = resp_q;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = data_q;
    assign bus.reg_we      = reg_we_c;
    assign bus.frame_count = frame_q;
    assign bus.err_count   = err_q;
    assign bus.overrun     = overrun_q;
endmodule
